// File: rtl/vmul_pkg.sv
// Shared encodings for the vector multiply sequencer.
package vmul_pkg;

  // Controller state encoding; 2'd3 is illegal and recovers to IDLE.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } state_e;

  // Product half selection.
  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

endpackage

// File: rtl/mul_array.sv
// Combinational unsigned WIDTH x WIDTH multiplier producing the full 2*WIDTH product.
// BEHAVIORAL selects a plain '*'; otherwise partial products are summed row by row,
// either with an explicit bit-level ripple-carry adder or with a vector '+'.
module mul_array #(
  parameter int WIDTH        = 8,
  parameter bit BEHAVIORAL   = 1'b0,
  parameter bit RIPPLE_CARRY = 1'b1
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  generate
    if (BEHAVIORAL) begin : g_beh
      assign product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end else begin : g_arr
      logic [2*WIDTH-1:0] acc;
      logic [2*WIDTH-1:0] pp;
      logic [2*WIDTH-1:0] nxt;
      logic               carry;

      // Shift-and-add array: accumulate one gated partial product per multiplier bit.
      always_comb begin
        acc   = '0;
        pp    = '0;
        nxt   = '0;
        carry = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          pp = {{WIDTH{1'b0}}, (a & {WIDTH{b[i]}})} << i;
          if (RIPPLE_CARRY) begin
            carry = 1'b0;
            for (int j = 0; j < 2*WIDTH; j++) begin
              nxt[j] = acc[j] ^ pp[j] ^ carry;
              carry  = (acc[j] & pp[j]) | (carry & (acc[j] ^ pp[j]));
            end
          end else begin
            nxt = acc + pp;
          end
          acc = nxt;
        end
      end

      assign product = acc;
    end
  endgenerate

endmodule

// File: rtl/vmul_seq_ctrl.sv
// Vector multiply sequencer: walks the elements of a latched operand pair through a
// single shared mul_array, one element per cycle, and presents the assembled result
// vector with a valid/ready handshake.
module vmul_seq_ctrl
  import vmul_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NUM_ELEM     = 4,
  parameter bit BEHAVIORAL   = 1'b0,
  parameter bit RIPPLE_CARRY = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_ELEM*WIDTH-1:0] in_a,
  input  logic [NUM_ELEM*WIDTH-1:0] in_b,
  input  logic                      in_high,
  input  logic [NUM_ELEM-1:0]       in_mask,
  input  logic [NUM_ELEM*WIDTH-1:0] in_vd_old,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_ELEM*WIDTH-1:0] out_result,
  output logic                      busy
);

  localparam int              IDX_W    = $clog2(NUM_ELEM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  state_e                    state;
  logic [IDX_W-1:0]          idx;
  logic [NUM_ELEM*WIDTH-1:0] a_reg;
  logic [NUM_ELEM*WIDTH-1:0] b_reg;
  logic [NUM_ELEM*WIDTH-1:0] vd_old_reg;
  logic [NUM_ELEM-1:0]       mask_reg;
  logic                      high_reg;
  logic [NUM_ELEM*WIDTH-1:0] work;

  logic [WIDTH-1:0]          elem_a;
  logic [WIDTH-1:0]          elem_b;
  logic [2*WIDTH-1:0]        product;
  logic [WIDTH-1:0]          half;
  logic [WIDTH-1:0]          new_elem;
  logic [NUM_ELEM*WIDTH-1:0] merged;

  // Element-select mux feeding the shared multiplier, half select and mask merge.
  always_comb begin
    elem_a = a_reg[int'(idx)*WIDTH +: WIDTH];
    elem_b = b_reg[int'(idx)*WIDTH +: WIDTH];
    if (high_reg == SEL_HI) begin
      half = product[2*WIDTH-1:WIDTH];
    end else begin
      half = product[WIDTH-1:0];
    end
    if (mask_reg[idx]) begin
      new_elem = half;
    end else begin
      new_elem = vd_old_reg[int'(idx)*WIDTH +: WIDTH];
    end
    merged = work;
    merged[int'(idx)*WIDTH +: WIDTH] = new_elem;
  end

  mul_array #(
    .WIDTH        (WIDTH),
    .BEHAVIORAL   (BEHAVIORAL),
    .RIPPLE_CARRY (RIPPLE_CARRY)
  ) u_mul (
    .a       (elem_a),
    .b       (elem_b),
    .product (product)
  );

  // Controller FSM with registered handshake, busy and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      vd_old_reg <= '0;
      mask_reg   <= '0;
      high_reg   <= SEL_LO;
      work       <= '0;
      out_result <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          out_valid <= 1'b0;
          if (in_valid && in_ready && !flush) begin
            a_reg      <= in_a;
            b_reg      <= in_b;
            vd_old_reg <= in_vd_old;
            mask_reg   <= in_mask;
            high_reg   <= in_high;
            idx        <= '0;
            busy       <= 1'b1;
            in_ready   <= 1'b0;
            state      <= S_RUN;
          end else begin
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (flush) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end else begin
            work <= merged;
            if (idx == LAST_IDX) begin
              // Result is published only when the whole vector is complete.
              out_result <= merged;
              out_valid  <= 1'b1;
              state      <= S_DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          idx       <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmul_seq_ctrl.sv
// Scoreboard bench for vmul_seq_ctrl (WIDTH=8, NUM_ELEM=4): the driver pushes the
// hand-computed result of every request that should complete; a monitor pops and
// compares on every output handshake.
module tb_vmul_seq_ctrl;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_a;
  logic [N*W-1:0] in_b;
  logic           in_high;
  logic [N-1:0]   in_mask;
  logic [N*W-1:0] in_vd_old;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_result;
  logic           busy;

  int applied;
  int miscompares;
  logic [N*W-1:0] exp_q[$];

  vmul_seq_ctrl #(
    .WIDTH        (W),
    .NUM_ELEM     (N),
    .BEHAVIORAL   (1'b0),
    .RIPPLE_CARRY (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_high    (in_high),
    .in_mask    (in_mask),
    .in_vd_old  (in_vd_old),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand sets: element i sits at bits [i*8 +: 8].
  localparam logic [31:0] A0    = 32'h00FF0F03;  // {03,0F,FF,00}
  localparam logic [31:0] B0    = 32'h7FFF1005;  // {05,10,FF,7F}
  localparam logic [31:0] E_LO  = 32'h0001F00F;  // {0F,F0,01,00}
  localparam logic [31:0] E_HI  = 32'h00FE0000;  // {00,00,FE,00}
  localparam logic [31:0] E_MSK = 32'hAA01AA0F;  // {0F,AA,01,AA}
  localparam logic [31:0] A1    = 32'h05040302;  // {02,03,04,05}
  localparam logic [31:0] B1    = 32'h40302010;  // {10,20,30,40}
  localparam logic [31:0] E_BP  = 32'h40C06020;  // {20,60,C0,40}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one request and return #1 after the accept edge; inputs are then scrambled.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic high,
                      input logic [3:0] mask, input logic [31:0] vd,
                      input bit push, input logic [31:0] exp);
    int t;
    t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_a      = a;
    in_b      = b;
    in_high   = high;
    in_mask   = mask;
    in_vd_old = vd;
    in_valid  = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_a      = 32'hDEADBEEF;
    in_b      = 32'h12345678;
    in_high   = ~high;
    in_mask   = ~mask;
    in_vd_old = 32'h55555555;
  endtask

  // Count cycles after the accept edge until out_valid rises (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      applied++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got %h, expected no output", out_result);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_result !== e) begin
          miscompares++;
          $display("FAIL result: got %h, expected %h", out_result, e);
        end
      end
    end
  end

  initial begin
    int lat;
    logic bad;
    applied = 0;
    miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_high = 1'b0;
    in_mask = '0; in_vd_old = '0; flush = 1'b0; out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_busy",       {31'd0, busy},      32'd0);
    chk("rst_in_ready",   {31'd0, in_ready},  32'd0);
    chk("rst_out_result", out_result,         32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Low half, with latency and busy checks.
    send(A0, B0, 1'b0, 4'b1111, 32'h0, 1'b1, E_LO);
    chk("run_busy",     {31'd0, busy},     32'd1);
    chk("run_in_ready", {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    chk("latency_full_mask", lat, 32'd4);
    @(posedge clk); #1;

    // High half.
    send(A0, B0, 1'b1, 4'b1111, 32'h0, 1'b1, E_HI);
    wait_valid(lat);
    chk("latency_high", lat, 32'd4);
    @(posedge clk); #1;

    // Masked elements take vd_old and still cost a cycle.
    send(A0, B0, 1'b0, 4'b0101, 32'hAAAAAAAA, 1'b1, E_MSK);
    wait_valid(lat);
    chk("latency_masked", lat, 32'd4);
    @(posedge clk); #1;

    // Backpressure: hold DONE for three cycles.
    out_ready = 1'b0;
    send(A1, B1, 1'b0, 4'b1111, 32'h0, 1'b1, E_BP);
    wait_valid(lat);
    chk("latency_bp", lat, 32'd4);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_out_valid",  {31'd0, out_valid}, 32'd1);
      chk("bp_out_result", out_result,         E_BP);
      chk("bp_in_ready",   {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
    chk("idle_keeps_result",    out_result,         E_BP);

    // Reset while idx==2: outputs clear immediately, then recovery.
    send(A0, B0, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("midrst_out_result", out_result,         32'd0);
    chk("midrst_busy",       {31'd0, busy},      32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    send(A0, B0, 1'b1, 4'b1111, 32'h0, 1'b1, E_HI);
    wait_valid(lat);
    chk("latency_after_rst", lat, 32'd4);
    @(posedge clk); #1;

    // Flush in RUN with a competing request.
    send(A1, B1, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_a = A0; in_b = B0; in_mask = 4'b1111; in_high = 1'b0;
    @(posedge clk); #1;
    chk("flush_busy",     {31'd0, busy},     32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("flush_blocks_accept", {31'd0, busy}, 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid || busy) bad = 1'b1;
    end
    chk("flush_no_output", {31'd0, bad}, 32'd0);

    // Recovery after flush.
    send(A0, B0, 1'b0, 4'b0101, 32'hAAAAAAAA, 1'b1, E_MSK);
    wait_valid(lat);
    chk("latency_after_flush", lat, 32'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
